// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// S_FAULT exists only when FETCH_ALIGN_CHECK_EN is defined.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_ADDR,
        S_WAIT,
        S_CAPT,
        S_HOLD
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        S_FAULT
`endif
    } fetch_state_e;

    localparam int unsigned INSN_BYTES   = 4;
    localparam int unsigned MAX_MEM_WAIT = 15;
    localparam logic [31:0] NOP_WORD     = 32'h0;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC arithmetic: sequential PC+4, branch target and the taken select.
// With FETCH_ALIGN_CHECK_EN undefined, the low target bits are cleared.
module fetch_next_pc
    import fetch_pkg::*;
(
    input  logic [63:0] pc_i,
    input  logic [63:0] branch_pc_i,
    input  logic [63:0] imm_i,
    input  logic        branch_i,
    input  logic        uncond_i,
    input  logic        alu_zero_i,
    output logic [63:0] pc_plus4_o,
    output logic [63:0] target_o,
    output logic        taken_o
);

    logic [63:0] raw_target;

    assign pc_plus4_o = pc_i + 64'(INSN_BYTES);
    // imm is a word offset; the shift drops its top two bits by design
    assign raw_target = branch_pc_i + (imm_i << 2);

`ifdef FETCH_ALIGN_CHECK_EN
    assign target_o = raw_target;
`else
    assign target_o = raw_target & ~64'h3;
`endif

    assign taken_o = uncond_i | (branch_i & alu_zero_i);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, waits MEM_WAIT cycles for memory, presents the word
// with valid/ready and applies branch redirects. Option: FETCH_ALIGN_CHECK_EN.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          MEM_WAIT = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [63:0] Address,
    input  logic [31:0] Data,
    output logic [31:0] Instruction,
    output logic [63:0] InstPC,
    output logic        InstValid,
    input  logic        InstReady,
    input  logic        Branch,
    input  logic        Uncondbranch,
    input  logic        ALUZero,
    input  logic [63:0] BranchPC,
    input  logic [63:0] SignExtImm64
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        AlignFault
`endif
);

    localparam logic [3:0] WAIT_INIT =
        4'((MEM_WAIT > int'(MAX_MEM_WAIT)) ? int'(MAX_MEM_WAIT) : MEM_WAIT);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [31:0]  insn_q, insn_d;
    logic [63:0]  ipc_q, ipc_d;
    logic         valid_q, valid_d;
    logic         fault_q, fault_d;
    logic [63:0]  pc_plus4;
    logic [63:0]  target;
    logic         taken;

    fetch_next_pc u_next_pc (
        .pc_i        (pc_q),
        .branch_pc_i (BranchPC),
        .imm_i       (SignExtImm64),
        .branch_i    (Branch),
        .uncond_i    (Uncondbranch),
        .alu_zero_i  (ALUZero),
        .pc_plus4_o  (pc_plus4),
        .target_o    (target),
        .taken_o     (taken)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_ADDR;
            pc_q    <= RESET_PC;
            cnt_q   <= 4'd0;
            insn_q  <= NOP_WORD;
            ipc_q   <= 64'h0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            insn_q  <= insn_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        insn_d  = insn_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        fault_d = fault_q;

        case (state_q)
            S_ADDR: begin
                if (WAIT_INIT == 4'd0) begin
                    state_d = S_CAPT;
                end else begin
                    cnt_d   = WAIT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_CAPT;
            end
            S_CAPT: begin
                insn_d  = Data;
                ipc_d   = pc_q;
                valid_d = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (InstReady) begin
                    valid_d = 1'b0;
                    pc_d    = pc_plus4;
                    state_d = S_ADDR;
                end
            end
            default: state_d = state_q;
        endcase

        // A taken redirect overrides everything above, including a handshake
`ifdef FETCH_ALIGN_CHECK_EN
        if (taken && state_q != S_FAULT) begin
            pc_d    = target;
            valid_d = 1'b0;
            state_d = S_ADDR;
            if (target[1:0] != 2'b00) begin
                fault_d = 1'b1;
                state_d = S_FAULT;
            end
        end
`else
        if (taken) begin
            pc_d    = target;
            valid_d = 1'b0;
            state_d = S_ADDR;
        end
`endif
    end

    assign Address     = pc_q;
    assign Instruction = insn_q;
    assign InstPC      = ipc_q;
    assign InstValid   = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign AlignFault  = fault_q;
`else
    logic unused_fault;
    assign unused_fault = fault_q;
`endif

endmodule
